// File: rtl/hazard_pkg.sv
// Shared latency defaults and counter-width helper for the hazard scoreboard.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int NUM_SRC_DEF    = 2;
  localparam int ALU_LAT_DEF    = 1;
  localparam int LOAD_LAT_DEF   = 2;
  localparam int WB_LAT_DEF     = 3;

  // Width needed to hold L-1 for the largest latency; never narrower than one bit.
  function automatic int cnt_width(input int alu_lat, input int load_lat, input int wb_lat);
    int m;
    m = alu_lat;
    if (load_lat > m) m = load_lat;
    if (wb_lat > m) m = wb_lat;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-stage bundle between the ID stage (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_SRC    = NUM_SRC_DEF
);

  logic                            issue_valid;
  logic                            issue_wb_en;
  logic                            issue_is_load;
  logic [REG_ADDR_W-1:0]           issue_dest;
  logic [NUM_SRC*REG_ADDR_W-1:0]   src_addr;
  logic [NUM_SRC-1:0]              src_valid;
  logic                            forward_en;
  logic                            flush;
  logic                            stall;
  logic [(2**REG_ADDR_W)-1:0]      busy_vec;
  logic [31:0]                     stall_cycles;

  modport master (
    output issue_valid, issue_wb_en, issue_is_load, issue_dest,
           src_addr, src_valid, forward_en, flush,
    input  stall, busy_vec, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_wb_en, issue_is_load, issue_dest,
           src_addr, src_valid, forward_en, flush,
    output stall, busy_vec, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register countdown: load wins over decrement, decrement saturates at zero.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_busy = (r_count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard with per-register countdowns and combinational stall.
// Define HAZARD_PERF_EN to build the saturating stall_cycles counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int ALU_LAT    = ALU_LAT_DEF,
  parameter int LOAD_LAT   = LOAD_LAT_DEF,
  parameter int WB_LAT     = WB_LAT_DEF
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb_if
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int CNT_W    = cnt_width(ALU_LAT, LOAD_LAT, WB_LAT);

  localparam logic [CNT_W-1:0] ALU_VAL  = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] WB_VAL   = CNT_W'(WB_LAT - 1);

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_SRC-1:0]  w_src_hit;
  logic                w_stall;
  logic                w_accept;
  logic [CNT_W-1:0]    w_load_val;

  // Sources look at pre-update counters, so an instruction never waits on its own dest.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_src_hit[gi] = sb_if.src_valid[gi] &
                           w_busy[sb_if.src_addr[gi*REG_ADDR_W +: REG_ADDR_W]];
  end

  assign w_stall  = sb_if.issue_valid & ~sb_if.flush & (|w_src_hit);
  assign w_accept = sb_if.issue_valid & ~w_stall & ~sb_if.flush &
                    sb_if.issue_wb_en & (sb_if.issue_dest != '0);

  always_comb begin
    w_load_val = ALU_VAL;
    if (!sb_if.forward_en) begin
      w_load_val = WB_VAL;
    end else if (sb_if.issue_is_load) begin
      w_load_val = LOAD_VAL;
    end
  end

  assign w_busy[0] = 1'b0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_accept && (sb_if.issue_dest == REG_ADDR_W'(gi))),
      .i_load_val (w_load_val),
      .o_busy     (w_busy[gi])
    );
  end

  assign sb_if.stall    = w_stall;
  assign sb_if.busy_vec = w_busy;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign sb_if.stall_cycles = r_stall_cycles;
`else
  assign sb_if.stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard, plus an async-reset sequence.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NV = 32;
`ifdef HAZARD_PERF_EN
  localparam logic [31:0] PERF_STEP = 32'd1;
`else
  localparam logic [31:0] PERF_STEP = 32'd0;
`endif

  logic clk;
  logic rst_n;

  hazard_scoreboard_if #(.REG_ADDR_W(5), .NUM_SRC(2)) sb_if ();

  hazard_scoreboard #(
    .REG_ADDR_W(5), .NUM_SRC(2), .ALU_LAT(1), .LOAD_LAT(2), .WB_LAT(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb_if (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       wb;
    logic       ld;
    logic [4:0] dest;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] sv;
    logic       fwd;
    logic       fl;
    logic [4:0] chk;
    logic       exp_stall;
    logic       exp_busy;
  } vec_t;

  vec_t        tv [NV];
  int          n_pass;
  int          n_total;
  logic [31:0] exp_perf;

  function automatic vec_t mk(input int v, input int wb, input int ld, input int d,
                              input int s0, input int s1, input int sv, input int fwd,
                              input int fl, input int c, input int es, input int eb);
    vec_t r;
    r.valid = v[0];  r.wb = wb[0];  r.ld = ld[0];
    r.dest = d[4:0]; r.s0 = s0[4:0]; r.s1 = s1[4:0]; r.sv = sv[1:0];
    r.fwd = fwd[0];  r.fl = fl[0];  r.chk = c[4:0];
    r.exp_stall = es[0]; r.exp_busy = eb[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.issue_valid   = v.valid;
    sb_if.issue_wb_en   = v.wb;
    sb_if.issue_is_load = v.ld;
    sb_if.issue_dest    = v.dest;
    sb_if.src_addr      = {v.s1, v.s0};
    sb_if.src_valid     = v.sv;
    sb_if.forward_en    = v.fwd;
    sb_if.flush         = v.fl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass   = 0;
    n_total  = 0;
    exp_perf = 32'd0;

    //        v  wb ld dst s0  s1 sv fwd fl chk st by
    tv[0]  = mk(1, 1, 0,  5,  0, 0, 0, 1, 0,  5, 0, 0);  // ALU dest 5
    tv[1]  = mk(1, 0, 0,  0,  5, 0, 1, 1, 0,  5, 0, 0);  // forwarded, no stall
    tv[2]  = mk(1, 1, 1,  5,  0, 0, 0, 1, 0,  5, 0, 0);  // load dest 5
    tv[3]  = mk(1, 0, 0,  0,  0, 5, 2, 1, 0,  5, 1, 1);  // src1 reads 5: stall
    tv[4]  = mk(1, 0, 0,  0,  0, 5, 2, 1, 0,  5, 0, 0);  // issues
    tv[5]  = mk(1, 1, 0,  7,  0, 0, 0, 0, 0,  7, 0, 0);  // no-forward ALU dest 7
    tv[6]  = mk(1, 0, 0,  0,  7, 0, 1, 0, 0,  7, 1, 1);
    tv[7]  = mk(1, 0, 0,  0,  7, 0, 1, 0, 0,  7, 1, 1);
    tv[8]  = mk(1, 0, 0,  0,  7, 0, 1, 0, 0,  7, 0, 0);
    tv[9]  = mk(1, 1, 1,  8,  0, 0, 0, 0, 0,  8, 0, 0);  // fwd off at issue
    tv[10] = mk(1, 0, 0,  0,  8, 0, 1, 1, 0,  8, 1, 1);  // fwd on later: still WB_LAT
    tv[11] = mk(1, 0, 0,  0,  8, 0, 1, 1, 0,  8, 1, 1);
    tv[12] = mk(1, 0, 0,  0,  8, 0, 1, 1, 0,  8, 0, 0);
    tv[13] = mk(1, 1, 1,  9,  0, 0, 0, 1, 0,  9, 0, 0);  // load dest 9
    tv[14] = mk(1, 0, 0,  0,  9, 9, 0, 1, 0,  9, 0, 1);  // immediate: no stall
    tv[15] = mk(1, 1, 1,  0,  0, 0, 0, 1, 0,  0, 0, 0);  // writer to r0
    tv[16] = mk(1, 0, 0,  0,  0, 0, 3, 1, 0,  0, 0, 0);  // reader of r0
    tv[17] = mk(1, 1, 1, 11, 11, 0, 1, 1, 0, 11, 0, 0);  // src == own dest
    tv[18] = mk(1, 0, 0,  0, 11, 0, 1, 1, 0, 11, 1, 1);
    tv[19] = mk(1, 0, 0,  0, 11, 0, 1, 1, 0, 11, 0, 0);
    tv[20] = mk(1, 1, 0,  6,  0, 0, 0, 0, 0,  6, 0, 0);  // older producer dest 6
    tv[21] = mk(1, 1, 1,  4,  6, 0, 1, 1, 1,  6, 0, 1);  // flushed load dest 4
    tv[22] = mk(1, 0, 0,  0,  4, 0, 1, 1, 0,  4, 0, 0);  // reader of 4: no stall
    tv[23] = mk(0, 0, 0,  0,  0, 0, 0, 1, 0,  6, 0, 0);  // dest 6 cleared
    tv[24] = mk(1, 1, 0, 13,  0, 0, 0, 0, 0, 13, 0, 0);
    tv[25] = mk(0, 0, 0,  0, 13, 0, 1, 0, 0, 13, 0, 1);  // not valid: no stall
    tv[26] = mk(1, 0, 0,  0, 13, 0, 1, 0, 0, 13, 1, 1);
    tv[27] = mk(1, 0, 0,  0, 13, 0, 1, 0, 0, 13, 0, 0);
    tv[28] = mk(1, 1, 1, 14,  0, 0, 0, 1, 0, 14, 0, 0);
    tv[29] = mk(1, 1, 0, 15, 14, 0, 1, 0, 0, 15, 1, 0);  // stalled writer
    tv[30] = mk(1, 1, 0, 15, 14, 0, 1, 0, 0, 15, 0, 0);  // retries and issues
    tv[31] = mk(0, 0, 0,  0,  0, 0, 0, 1, 0, 15, 0, 1);

    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy_vec", sb_if.busy_vec, 32'd0);
    chk("reset stall", {31'd0, sb_if.stall}, 32'd0);
    chk("reset stall_cycles", sb_if.stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, sb_if.stall}, {31'd0, tv[i].exp_stall});
      chk($sformatf("v%0d busy[%0d]", i, tv[i].chk), {31'd0, sb_if.busy_vec[tv[i].chk]},
          {31'd0, tv[i].exp_busy});
      chk($sformatf("v%0d stall_cycles", i), sb_if.stall_cycles, exp_perf);
      $display("vec %0d: stall=%0b busy[%0d]=%0b stall_cycles=%0d", i, sb_if.stall,
               tv[i].chk, sb_if.busy_vec[tv[i].chk], sb_if.stall_cycles);
      if (tv[i].exp_stall) exp_perf += PERF_STEP;
      @(negedge clk);
    end

    // Asynchronous reset while register 3 is pending.
    drive(mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    #1;
    chk("pre-reset busy[3]", {31'd0, sb_if.busy_vec[3]}, 32'd1);
    chk("pre-reset stall_cycles", sb_if.stall_cycles, exp_perf);
    rst_n = 1'b0;
    #1;
    chk("async reset busy_vec", sb_if.busy_vec, 32'd0);
    chk("async reset stall_cycles", sb_if.stall_cycles, 32'd0);
    $display("async reset: busy_vec=%0h stall_cycles=%0d", sb_if.busy_vec, sb_if.stall_cycles);
    #1;
    rst_n = 1'b1;
    drive(mk(1, 0, 0, 0, 3, 0, 1, 1, 0, 0, 0, 0));
    #1;
    chk("post-reset reader of 3 stall", {31'd0, sb_if.stall}, 32'd0);
    $display("post-reset reader of r3: stall=%0b", sb_if.stall);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    #1;
    chk("post-reset busy_vec", sb_if.busy_vec, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands checked per issuing instruction (1..4).
REQ-003 SHALL have parameter ALU_LAT, default 1, producer-to-consumer issue distance for non-load results with forwarding.
REQ-004 SHALL have parameter LOAD_LAT, default 2, the same distance for load results with forwarding.
REQ-005 SHALL have parameter WB_LAT, default 3, the same distance for any result without forwarding.
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- issue_valid, in, 1: instruction in ID requests issue.
- issue_wb_en, in, 1: the issuing instruction writes a register.
- issue_is_load, in, 1: the issuing instruction is a load.
- issue_dest, in, REG_ADDR_W: destination register.
- src_addr, in, NUM_SRC*REG_ADDR_W: packed source registers; src 0 in the LSBs.
- src_valid, in, NUM_SRC: per-source "operand actually read" flag (immediate/store/branch decode).
- forward_en, in, 1: forwarding network enabled.
- flush, in, 1: ID instruction squashed this cycle.
- stall, out, 1: hold PC and IF/ID; insert a bubble.
- busy_vec, out, 2**REG_ADDR_W: bit r set when the counter for register r is nonzero.
- stall_cycles, out, 32: performance counter.

Function
REQ-007 SHALL hold one countdown counter per register, width clog2(max(ALU_LAT,LOAD_LAT,WB_LAT)).
REQ-008 Register 0 SHALL never be busy; its counter SHALL be held at 0.
REQ-009 stall SHALL be combinational: issue_valid & ~flush & (OR over i of src_valid[i] & counter[src_addr[i]]!=0).
REQ-010 Accepted issue = issue_valid & ~stall & ~flush & issue_wb_en & issue_dest!=0.
REQ-011 On an accepted issue, counter[issue_dest] SHALL load L-1 at the next edge. L = WB_LAT if ~forward_en, else LOAD_LAT if issue_is_load, else ALU_LAT.
REQ-012 Every other nonzero counter SHALL decrement by 1 per cycle, saturating at 0.
REQ-013 A load to a counter SHALL take priority over its decrement in the same cycle.
REQ-014 Source checks SHALL use pre-update counter values; an instruction whose src equals its own dest SHALL not stall on itself.
REQ-015 flush SHALL suppress the current issue's counter load and force stall=0. Counters of older in-flight producers SHALL keep decrementing.
REQ-016 A forward_en change SHALL affect only subsequent issues; existing counters SHALL not be modified.
REQ-017 A stalled instruction SHALL not load any counter; it re-evaluates every cycle until stall drops.
REQ-018 Latency parameters equal to 1 SHALL produce no stall for that producer class.

Reset
REQ-019 rst_n low SHALL asynchronously clear all counters. busy_vec=0, stall=0, stall_cycles=0.
REQ-020 Reset deassertion SHALL be used synchronously: the first counter update occurs on the first edge with rst_n high.
REQ-021 Reset mid-operation SHALL discard all pending hazards; there is no replay.

Configuration
REQ-022 Macro HAZARD_PERF_EN defined: stall_cycles SHALL increment, saturating at 32'hFFFF_FFFF, on every edge where stall=1.
REQ-023 Macro HAZARD_PERF_EN undefined: stall_cycles SHALL be tied to 0, with no counter logic synthesised; the port remains.

Structure
REQ-024 The latency defaults, REG_ADDR_W default, and a helper for the counter width SHALL live in shared package hazard_pkg.
REQ-025 The per-register counter SHALL be sub-module sb_counter (load, load value, auto-decrement, nonzero flag), instantiated 2**REG_ADDR_W - 1 times via generate.

Verification
REQ-026 Defaults, forward_en=1: ALU issue dest=5, next cycle src0=5 valid -> stall=0 both cycles.
REQ-027 forward_en=1: load dest=5, next cycle src1=5 valid -> stall=1 for exactly 1 cycle, issues on the second; with HAZARD_PERF_EN, stall_cycles=1.
REQ-028 forward_en=0: ALU dest=7, next src0=7 -> stall for 2 cycles; busy_vec[7] goes 1,1,0.
REQ-029 Load dest=9 and a consumer reading 9 with src_valid=0 (immediate) -> stall=0. Writer with dest=0 followed by a reader of 0 -> stall=0.
REQ-030 Load dest=4 issued with flush=1, next cycle reader of 4 -> stall=0. Older pending dest=6 still clears on schedule.
REQ-031 rst_n pulsed low while busy_vec[3]=1 -> busy_vec=0 immediately; no stall for a subsequent reader of 3.
